// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data memory responder for the MEM stage.
// One request in flight at a time. Loads read at the edge entering RESP and stores commit at the edge leaving RESP.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic w_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic accept, to_resp, a_write, a_fault;
  logic [31:0] a_addr;
  logic [AW-1:0] a_idx;
  // In IDLE the live request is decoded so a LATENCY of 1 can respond straight from accept.
  always_comb begin
    accept = state == IDLE && req_valid && req_ready;
    a_write = state == IDLE ? req_write : w_q;
    a_addr = state == IDLE ? req_addr : addr_q;
    a_idx = a_addr[AW+1:2];
    a_fault = a_addr[1:0] != 2'b00 || {2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS);
    to_resp = (accept && LATENCY == 1) || (state == WAIT && cnt == 4'd1);
    nxt = to_resp ? RESP : accept ? WAIT : state == RESP ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      w_q <= 1'b0;
      addr_q <= 32'd0;
      wdata_q <= 32'd0;
      be_q <= 4'd0;
      req_ready <= 1'b0;
      busy <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err <= 1'b0;
    end else begin
      state <= nxt;
      req_ready <= nxt == IDLE;
      busy <= nxt != IDLE;
      resp_valid <= to_resp;
      resp_err <= to_resp && a_fault;
      resp_rdata <= (to_resp && !a_write && !a_fault) ? mem[a_idx] : 32'd0;
      if (accept) begin
        w_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        be_q <= req_byte_en;
        cnt <= 4'(LATENCY - 1);
      end else if (state == WAIT) cnt <= cnt - 4'd1;
    end
  end
  // Storage is never reset; a reset landing on the RESP edge cancels the commit.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && w_q && !a_fault)
      for (int i = 0; i < 4; i++)
        if (be_q[i]) mem[a_idx][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of two responder instances (LATENCY 2 and 1) against a word-array model.
module tb_dmem_responder;
  localparam int D0 = 256, L0 = 2, D1 = 16, L1 = 1;
  logic clk = 1'b0, reset = 1'b0;
  logic valid0 = 1'b0, valid1 = 1'b0;
  logic req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0] req_byte_en = '0;
  logic ready0, ready1, rv0, rv1, err0, err1, busy0, busy1;
  logic [31:0] rdata0, rdata1;
  logic c_ready, c_rv, c_err, c_busy;
  logic [31:0] c_rdata;
  int errors = 0, checks = 0, sel = 0;
  logic [31:0] model [2][256];
  typedef struct packed {logic w; logic [31:0] a; logic [31:0] d; logic [3:0] be; logic [31:0] rd; logic e;} op_t;
  op_t ops [10];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(D0), .LATENCY(L0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_ready(ready0), .resp_valid(rv0),
    .resp_rdata(rdata0), .resp_err(err0), .busy(busy0));
  dmem_responder #(.DEPTH_WORDS(D1), .LATENCY(L1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_byte_en(req_byte_en), .req_ready(ready1), .resp_valid(rv1),
    .resp_rdata(rdata1), .resp_err(err1), .busy(busy1));

  assign c_ready = sel != 0 ? ready1 : ready0;
  assign c_rv = sel != 0 ? rv1 : rv0;
  assign c_err = sel != 0 ? err1 : err0;
  assign c_busy = sel != 0 ? busy1 : busy0;
  assign c_rdata = sel != 0 ? rdata1 : rdata0;

  function automatic int lat();
    return sel != 0 ? L1 : L0;
  endfunction
  function automatic int depth();
    return sel != 0 ? D1 : D0;
  endfunction

  // Reference: a request either faults, or stores enabled lanes, or returns the whole word.
  task automatic model_req(input logic w, input logic [31:0] a, d, input logic [3:0] be,
                           output logic [31:0] rd, output logic e);
    e = a[1:0] != 2'b00 || (a >> 2) >= 32'(depth());
    if (w && !e)
      for (int i = 0; i < 4; i++) if (be[i]) model[sel][a >> 2][8*i +: 8] = d[8*i +: 8];
    rd = (!w && !e) ? model[sel][a >> 2] : 32'd0;
  endtask

  // Called at a negedge with the selected DUT idle; returns at the negedge after the response cycle.
  task automatic do_req(input logic w, input logic [31:0] a, d, input logic [3:0] be,
                        output int l, output logic [31:0] rd, output logic e, output logic pa);
    int n = 0;
    req_write = w; req_addr = a; req_wdata = d; req_byte_en = be;
    if (sel != 0) valid1 = 1'b1; else valid0 = 1'b1;
    while (!c_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    valid0 = 1'b0; valid1 = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_byte_en = 4'($urandom);
    l = 1;
    while (!c_rv && l < 20) begin @(negedge clk); l++; end
    rd = c_rdata; e = c_err;
    @(negedge clk);
    pa = c_rv | c_err | (|c_rdata);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({ready0, ready1, rv0, rv1, err0, err1, busy0, busy1, rdata0, rdata1} !== '0)
      begin errors++; $display("FAIL reset_state: got rdy=%b%b rv=%b%b busy=%b%b rd=%h/%h want all 0", ready0, ready1, rv0, rv1, busy0, busy1, rdata0, rdata1); end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready0, ready1, busy0, busy1, rv0, rv1} !== 6'b110000)
      begin errors++; $display("FAIL reset_release: got rdy=%b%b busy=%b%b rv=%b%b want rdy=11 busy=00 rv=00", ready0, ready1, busy0, busy1, rv0, rv1); end
  endtask

  task automatic test_init();
    int l; logic [31:0] rd, xr; logic e, xe, pa, w;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < depth(); i++) begin
        w = 1'b1;
        xr = $urandom;
        do_req(w, 32'(i * 4), xr, 4'hf, l, rd, e, pa);
        model_req(w, 32'(i * 4), xr, 4'hf, xr, xe);
        checks++;
        if ({l, rd, e, pa} !== {lat(), xr, xe, 1'b0})
          begin errors++; $display("FAIL init_store[%0d/%0d]: got lat=%0d rd=%h err=%b after=%b want lat=%0d rd=%h err=%b after=0", s, i, l, rd, e, pa, lat(), xr, xe); end
      end
    end
  endtask

  task automatic test_spec_ops();
    int l; logic [31:0] rd, xr; logic e, xe, pa;
    sel = 0;
    ops[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0};
    ops[1] = '{1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0};
    ops[2] = '{1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'h0, 1'b0};
    ops[3] = '{1'b0, 32'h10, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0};
    ops[4] = '{1'b0, 32'h12, 32'h0, 4'b1111, 32'h0, 1'b1};
    ops[5] = '{1'b0, 32'h400, 32'h0, 4'b1111, 32'h0, 1'b1};
    ops[6] = '{1'b1, 32'h11, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1};
    ops[7] = '{1'b1, 32'h10, 32'h11111111, 4'b0000, 32'h0, 1'b0};
    ops[8] = '{1'b1, 32'h400, 32'h22222222, 4'b1111, 32'h0, 1'b1};
    ops[9] = '{1'b0, 32'h10, 32'h0, 4'b0101, 32'hDEADAAEF, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do_req(ops[i].w, ops[i].a, ops[i].d, ops[i].be, l, rd, e, pa);
      model_req(ops[i].w, ops[i].a, ops[i].d, ops[i].be, xr, xe);
      checks++;
      if ({l, rd, e, pa} !== {L0, ops[i].rd, ops[i].e, 1'b0})
        begin errors++; $display("FAIL spec_op[%0d]: got lat=%0d rd=%h err=%b after=%b want lat=%0d rd=%h err=%b after=0", i, l, rd, e, pa, L0, ops[i].rd, ops[i].e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xr;
    sel = 0;
    req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; req_byte_en = 4'hf;
    valid0 = 1'b1;
    for (int t = 0; t < 10; t++) begin
      xr = (t % 3 == 2) ? model[0][4] : 32'd0;
      checks++;
      if ({ready0, busy0, rv0, rdata0} !== {t % 3 == 0, t % 3 != 0, t % 3 == 2, xr})
        begin errors++; $display("FAIL back_to_back[c%0d]: got rdy=%b busy=%b rv=%b rd=%h want rdy=%b busy=%b rv=%b rd=%h", t, ready0, busy0, rv0, rdata0, t % 3 == 0, t % 3 != 0, t % 3 == 2, xr); end
      if (t == 7) valid0 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int l, hits = 0; logic [31:0] rd; logic e, pa;
    sel = 0;
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_byte_en = 4'hf;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ready0, busy0, rv0} !== 3'b000)
      begin errors++; $display("FAIL reset_in_wait: got rdy=%b busy=%b rv=%b want 000", ready0, busy0, rv0); end
    reset = 1'b1;
    repeat (4) begin @(negedge clk); if (rv0) hits++; end
    checks++;
    if (hits !== 0) begin errors++; $display("FAIL reset_no_resp: got %0d responses want 0", hits); end
    do_req(1'b0, 32'h20, 32'h0, 4'hf, l, rd, e, pa);
    checks++;
    if ({l, rd, e} !== {L0, model[0][8], 1'b0})
      begin errors++; $display("FAIL reset_wait_keep: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=0", l, rd, e, L0, model[0][8]); end
    req_write = 1'b1; req_addr = 32'h24; req_wdata = ~model[0][9]; req_byte_en = 4'hf;
    valid0 = 1'b1;
    @(negedge clk);
    valid0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_req(1'b0, 32'h24, 32'h0, 4'hf, l, rd, e, pa);
    checks++;
    if ({l, rd, e} !== {L0, model[0][9], 1'b0})
      begin errors++; $display("FAIL reset_resp_keep: got lat=%0d rd=%h err=%b want lat=%0d rd=%h err=0", l, rd, e, L0, model[0][9]); end
  endtask

  task automatic test_latency1();
    int l; logic [31:0] rd, xr; logic e, xe, pa;
    sel = 1;
    do_req(1'b1, 32'h04, 32'hCAFEF00D, 4'hf, l, rd, e, pa);
    model_req(1'b1, 32'h04, 32'hCAFEF00D, 4'hf, xr, xe);
    checks++;
    if ({l, rd, e, pa} !== {32'd1, 32'h0, 1'b0, 1'b0})
      begin errors++; $display("FAIL lat1_store: got lat=%0d rd=%h err=%b after=%b want lat=1 rd=0 err=0 after=0", l, rd, e, pa); end
    do_req(1'b0, 32'h04, 32'h0, 4'h0, l, rd, e, pa);
    checks++;
    if ({l, rd, e, pa} !== {32'd1, 32'hCAFEF00D, 1'b0, 1'b0})
      begin errors++; $display("FAIL lat1_load: got lat=%0d rd=%h err=%b after=%b want lat=1 rd=cafef00d err=0 after=0", l, rd, e, pa); end
    do_req(1'b0, 32'h40, 32'h0, 4'hf, l, rd, e, pa);
    checks++;
    if ({l, rd, e} !== {32'd1, 32'h0, 1'b1})
      begin errors++; $display("FAIL lat1_range: got lat=%0d rd=%h err=%b want lat=1 rd=0 err=1", l, rd, e); end
  endtask

  task automatic test_random();
    int l, r; logic [31:0] rd, xr, a, d; logic e, xe, pa, w; logic [3:0] be;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int i = 0; i < 150; i++) begin
        r = int'($urandom_range(0, 9));
        a = 32'($urandom_range(0, depth() - 1)) << 2;
        if (r == 7) a = a | 32'($urandom_range(1, 3));
        if (r == 8) a = 32'(depth() * 4);
        if (r == 9) a = $urandom | 32'h8000_0000;
        w = 1'($urandom); d = $urandom; be = 4'($urandom);
        do_req(w, a, d, be, l, rd, e, pa);
        model_req(w, a, d, be, xr, xe);
        checks++;
        if ({l, rd, e, pa} !== {lat(), xr, xe, 1'b0})
          begin errors++; $display("FAIL random[%0d/%0d] w=%b a=%h be=%b: got lat=%0d rd=%h err=%b after=%b want lat=%0d rd=%h err=%b after=0", s, i, w, a, be, l, rd, e, pa, lat(), xr, xe); end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_spec_ops();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words of storage (power of two, 4..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to response (1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the MEM stage presents a request.
REQ-006 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32 bits: the byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: the store data.
REQ-009 SHALL have port req_byte_en, input, 4 bits: the store byte lanes, where bit i enables wdata[8i+7:8i].
REQ-010 SHALL have port req_ready, output, 1 bit: the responder accepts a request this cycle.
REQ-011 SHALL have port resp_valid, output, 1 bit: a one-cycle response pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: the load data, valid with resp_valid.
REQ-013 SHALL have port resp_err, output, 1 bit: the request faulted, valid with resp_valid.
REQ-014 SHALL have port busy, output, 1 bit: a request is in flight; the pipeline stalls while it is high.

Function
REQ-015 SHALL implement the states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready = 1 only in IDLE.
REQ-017 SHALL drive busy = 1 in WAIT and RESP.
REQ-018 SHALL accept a request on a cycle with req_valid && req_ready.
REQ-019 SHALL, on accept, latch write, addr, wdata and byte_en, and load the latency counter with LATENCY-1.
REQ-020 SHALL, on accept, go from IDLE to RESP if LATENCY = 1, otherwise to WAIT.
REQ-021 SHALL decrement the counter each cycle in WAIT and go to RESP on the cycle the counter reaches 1.
REQ-022 SHALL assert resp_valid exactly LATENCY cycles after the accept edge, for exactly one cycle, in RESP; RESP then returns to IDLE.
REQ-023 SHALL not support response backpressure: the requester always takes the response.
REQ-024 SHALL ignore changes on the req_* inputs outside the accept cycle.
REQ-025 SHALL flag a fault (resp_err = 1) when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS.
REQ-026 SHALL, on a fault, leave storage unmodified and drive resp_rdata = 0.
REQ-027 SHALL, for a store without a fault, update only the enabled byte lanes of word addr[31:2] at the RESP cycle edge.
REQ-028 SHALL, for a store without a fault, drive resp_rdata = 0 and resp_err = 0.
REQ-029 SHALL treat a store with byte_en = 0000 as a legal no-op that still produces a response.
REQ-030 SHALL, for a load without a fault, return the full word as stored at the time of the RESP cycle, regardless of byte_en, with resp_err = 0.
REQ-031 SHALL make a load accepted in the cycle right after a store response return the stored data (no read-after-write hazard).
REQ-032 SHALL sustain a maximum throughput of one request per LATENCY+1 cycles; a req_valid held through RESP is accepted in the following IDLE cycle.
REQ-033 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid = 0.

Reset
REQ-034 SHALL, while reset = 0 at a clock edge, enter IDLE, clear the counter and latches, and drive req_ready = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0 and busy = 0.
REQ-035 SHALL drive req_ready = 1 on the first cycle after reset deasserts.
REQ-036 SHALL, when reset hits mid-operation (WAIT or RESP), discard the pending request: no response is produced and no storage write occurs.
REQ-037 SHALL not clear storage contents on reset.

Verification
REQ-038 SHALL be verified by: LATENCY=2; store addr 0x10, wdata 0xDEADBEEF, byte_en 1111, then load 0x10 -> resp_valid 2 cycles after each accept, and the load returns 0xDEADBEEF with err 0.
REQ-039 SHALL be verified by: store 0x10, byte_en 0010, wdata 0x0000AA00, over 0xDEADBEEF -> a load of 0x10 returns 0xDEADAAEF.
REQ-040 SHALL be verified by: load 0x12 (misaligned), then load 4*DEPTH_WORDS (out of range) -> each gives resp_err 1 and rdata 0, and a following load of 0x10 is unchanged.
REQ-041 SHALL be verified by: req_valid held high for 3 loads -> accepts occur in cycles 0, 3 and 6, and busy is high in cycles 1-2, 4-5 and 7-8.
REQ-042 SHALL be verified by: store 0x20 with 0x12345678, then reset pulsed low during WAIT -> no resp_valid, and a post-reset load of 0x20 returns the prior contents.
REQ-043 SHALL be verified by: LATENCY=1; back-to-back store then load of 0x04 -> each resp_valid arrives 1 cycle after accept, and the load returns the stored word.
